riscv_mc_alu: RTL and testbench
===============================

Name: riscv_mc_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle RV32I ALU. It adds XOR, SLT/SLTU, shifts, and iterative MUL/MULHU/DIVU/REMU (RV M-subset). Operands are accepted and results returned through valid/ready handshakes, so the execute stage can stall on long operations. It sits in the execute stage, between operand muxing and the writeback/branch logic; `zero` still drives the branch decision.

Parameters:
- XLEN, 32: operand/result width; power of two, 8..64.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridable.
- CW, $clog2(XLEN+1): iteration-counter width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operands/op presented.
- o_ready  out  1  ALU can accept (high only in IDLE).
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B.
- alu_control  in  4  operation select (riscv_alu_pkg::alu_op_e).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_data  out  XLEN  result.
- zero  out  1  high when o_data == 0; qualified by o_valid.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, o_ready=1, o_valid=0, o_data=0, zero=1, busy=0, counter=0.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
  - 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned), 12 DIVU, 13 REMU.
  - 14, 15 reserved: result 0, completes in 1 cycle.
- Shifts use op_b[SHW-1:0] only.
- SLT/SLTU produce 0 or 1, zero-extended.
- Add/sub wrap modulo 2^XLEN.
- Accept: i_valid && o_ready at a rising edge latches op_a, op_b and alu_control.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - On accept with a single-cycle op, compute, register the result, go to DONE. o_valid rises on the next edge (latency 1).
  - On accept with MUL/MULHU/DIVU/REMU, load the working registers, counter=XLEN, busy=1, go to ITER.
- ITER:
  - Multiply: shift-add, one bit per cycle, over a 2·XLEN product register.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==1, register the final result and go to DONE. o_valid rises exactly XLEN cycles after the accept edge.
  - busy clears on entry to DONE.
- DIVU by 0: quotient all-ones; REMU by 0: remainder = op_a (RISC-V rule). Both complete via the normal XLEN-cycle path with no early exit, so latency is data-independent.
- DONE:
  - o_valid=1; o_data and zero held stable while i_ready=0.
  - On o_valid && i_ready, go to IDLE and drop o_valid the next cycle.
  - No accept in the DONE cycle: minimum initiation interval is 2 cycles for single-cycle ops.
- o_ready = (state==IDLE), combinational from state only; no combinational path from i_valid or i_ready to any output.
- i_valid toggling while not in IDLE is ignored.
- rst_n asserted mid-ITER or DONE: the in-flight op is dropped, reset values apply immediately.
- zero is registered together with o_data.

Decomposition:
- riscv_alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e (encodings above);
  - typedef enum logic [1:0] alu_state_e {IDLE, ITER, DONE};
  - function is_iter(alu_op_e).
- One natural sub-module, riscv_muldiv_iter: the shift-add/restoring datapath with start/done and a counter.
- The top holds the FSM, handshakes and the single-cycle datapath.

Test Plan:
- ADD 0xFFFF_FFFF + 1, i_ready=1 → o_valid one cycle after accept, o_data=0, zero=1. SUB 5−7 → 0xFFFF_FFFE, zero=0.
- SLT 0x8000_0000 vs 1 → 1; SLTU on the same operands → 0. SRA 0x8000_0000 by op_b=0x21 (shamt 1) → 0xC000_0000.
- MUL 0x0001_0000 × 0x0001_0000 → o_data=0, zero=1; MULHU on the same operands → 1. busy high for exactly 32 cycles, o_valid at cycle 32, o_ready low throughout.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 → 0xFFFF_FFFF; REMU 0x1234/0 → 0x1234.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → o_data stable, o_ready=0, a new i_valid is ignored. On the i_ready pulse → o_valid drops and o_ready rises the next cycle.
- Assert rst_n=0 at cycle 10 of a DIVU → all outputs return to reset values immediately. Next ADD 2+3 → 5 with normal latency. Repeat the suite with XLEN=8 and XLEN=64.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Shared types for the multi-cycle RV32I/M-subset ALU.
package riscv_alu_pkg;

   typedef enum logic [3:0] {
      AluAdd   = 4'd0,
      AluSub   = 4'd1,
      AluAnd   = 4'd2,
      AluOr    = 4'd3,
      AluXor   = 4'd4,
      AluSlt   = 4'd5,
      AluSltu  = 4'd6,
      AluSll   = 4'd7,
      AluSrl   = 4'd8,
      AluSra   = 4'd9,
      AluMul   = 4'd10,
      AluMulhu = 4'd11,
      AluDivu  = 4'd12,
      AluRemu  = 4'd13,
      AluRsv14 = 4'd14,
      AluRsv15 = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Ops that run through the iterative mul/div datapath.
   function automatic logic is_iter(alu_op_e op);
      return op inside {AluMul, AluMulhu, AluDivu, AluRemu};
   endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) datapath, one bit per cycle.
// acc holds the product high half or the partial remainder; lo holds the product
// low half (multiplier bits shift out) or the quotient (dividend bits shift out).
module riscv_muldiv_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            is_div,
   input  logic            sel_hi,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] acc_q, lo_q, b_q;
   logic [XLEN-1:0] acc_n, lo_n;
   logic [CW-1:0]   cnt_q;
   logic            div_q, hi_q;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;

   // One iteration step; the result port exposes the value the final step produces.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      if (div_q) begin
         // Divide by zero naturally yields all-ones quotient and remainder = dividend.
         acc_n = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
         lo_n  = {lo_q[XLEN-2:0], div_ge};
      end else begin
         acc_n = mul_sum[XLEN:1];
         lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      done   = (cnt_q == CW'(1));
      result = hi_q ? acc_n : lo_n;
   end

   // Working registers: load on start, step while the counter is non-zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
         hi_q  <= 1'b0;
      end else if (start) begin
         acc_q <= '0;
         lo_q  <= a;
         b_q   <= b;
         cnt_q <= CW'(XLEN);
         div_q <= is_div;
         hi_q  <= sel_hi;
      end else if (cnt_q != '0) begin
         acc_q <= acc_n;
         lo_q  <= lo_n;
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/riscv_mc_alu.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
module riscv_mc_alu
   import riscv_alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [3:0]      alu_control,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_data,
   output logic            zero,
   output logic            busy
);

   localparam int unsigned SHW = $clog2(XLEN);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            zero_q;
   alu_op_e         op;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic            md_start, md_done;
   logic [XLEN-1:0] md_result;

   assign op    = alu_op_e'(alu_control);
   assign shamt = op_b[SHW-1:0];

   // Single-cycle datapath, evaluated on the operands presented at accept.
   always_comb begin
      alu_res = '0;
      case (op)
         AluAdd:  alu_res = op_a + op_b;
         AluSub:  alu_res = op_a - op_b;
         AluAnd:  alu_res = op_a & op_b;
         AluOr:   alu_res = op_a | op_b;
         AluXor:  alu_res = op_a ^ op_b;
         AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         AluSltu: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         AluSll:  alu_res = op_a << shamt;
         AluSrl:  alu_res = op_a >> shamt;
         AluSra:  alu_res = $signed(op_a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   riscv_muldiv_iter #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .is_div (op inside {AluDivu, AluRemu}),
      .sel_hi (op inside {AluMulhu, AluRemu}),
      .a      (op_a),
      .b      (op_b),
      .done   (md_done),
      .result (md_result)
   );

   // Next-state and result capture; accept only happens in IDLE.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      md_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               if (is_iter(op)) begin
                  md_start = 1'b1;
                  state_d  = ITER;
               end else begin
                  data_d  = alu_res;
                  state_d = DONE;
               end
            end
         end
         ITER: begin
            if (md_done) begin
               data_d  = md_result;
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, result and zero flag registers; zero tracks o_data in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         zero_q  <= (data_d == '0);
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign busy    = (state_q == ITER);
   assign o_data  = data_q;
   assign zero    = zero_q;

endmodule

// File: tb/tb_riscv_mc_alu.sv
// Directed bench: XLEN=8, 32 and 64 instances driven in lockstep.
module tb_riscv_mc_alu;
   import riscv_alu_pkg::*;

   localparam int WID [3] = '{8, 32, 64};
   localparam logic [63:0] M8  = 64'hFF;
   localparam logic [63:0] M32 = 64'hFFFF_FFFF;
   localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [3:0]       op;
      logic [2:0][63:0] a;
      logic [2:0][63:0] b;
      logic [2:0][63:0] e;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             rdy_in;
   logic [3:0]       ctl;
   logic [2:0][63:0] a_in, b_in;
   logic [2:0]       ov, ordy, zr, bs;
   logic [7:0]       od8;
   logic [31:0]      od32;
   logic [63:0]      od64;
   logic [2:0][63:0] od;

   int tests;
   int fails;

   logic [63:0] got_data [3];
   logic        got_zero [3];
   int          got_lat  [3];
   int          busy_cnt [3];
   bit          rdy_seen [3];

   assign od[0] = 64'(od8);
   assign od[1] = 64'(od32);
   assign od[2] = od64;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   riscv_mc_alu #(.XLEN(8)) u_alu8 (
      .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .o_ready(ordy[0]),
      .op_a(a_in[0][7:0]), .op_b(b_in[0][7:0]), .alu_control(ctl), .o_valid(ov[0]),
      .i_ready(rdy_in), .o_data(od8), .zero(zr[0]), .busy(bs[0])
   );

   riscv_mc_alu #(.XLEN(32)) u_alu32 (
      .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .o_ready(ordy[1]),
      .op_a(a_in[1][31:0]), .op_b(b_in[1][31:0]), .alu_control(ctl), .o_valid(ov[1]),
      .i_ready(rdy_in), .o_data(od32), .zero(zr[1]), .busy(bs[1])
   );

   riscv_mc_alu #(.XLEN(64)) u_alu64 (
      .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .o_ready(ordy[2]),
      .op_a(a_in[2]), .op_b(b_in[2]), .alu_control(ctl), .o_valid(ov[2]),
      .i_ready(rdy_in), .o_data(od64), .zero(zr[2]), .busy(bs[2])
   );

   function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a8, a32, a64,
                               input logic [63:0] b8, b32, b64, e8, e32, e64);
      vec_t v;
      v.op = op;
      v.a  = {a64, a32, a8};
      v.b  = {b64, b32, b8};
      v.e  = {e64, e32, e8};
      return v;
   endfunction

   function automatic vec_t mks(input logic [3:0] op, input logic [63:0] a, b, e8, e32, e64);
      return mk(op, a, a, a, b, b, b, e8, e32, e64);
   endfunction

   // Present one op to all instances; returns #1 after the accept edge.
   task automatic issue(input vec_t v, input logic hold);
      @(negedge clk);
      ctl      = v.op;
      a_in     = v.a;
      b_in     = v.b;
      in_valid = 1'b1;
      rdy_in   = hold;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Sample index 0 is #1 after the accept edge, index n is #1 after the n-th later edge.
   task automatic collect();
      bit got [3];
      for (int k = 0; k < 3; k++) begin
         got[k] = 1'b0; got_lat[k] = -1; got_data[k] = '0; got_zero[k] = 1'b0;
         busy_cnt[k] = 0; rdy_seen[k] = 1'b0;
      end
      for (int s = 0; s < 100; s++) begin
         if (s > 0) begin
            @(posedge clk);
            #1;
         end
         for (int k = 0; k < 3; k++) begin
            if (!got[k]) begin
               if (ov[k]) begin
                  got[k] = 1'b1; got_lat[k] = s; got_data[k] = od[k]; got_zero[k] = zr[k];
               end else begin
                  if (bs[k]) busy_cnt[k]++;
                  if (ordy[k]) rdy_seen[k] = 1'b1;
               end
            end
         end
         if (got[0] && got[1] && got[2]) break;
      end
      rdy_in = 1'b1;
      @(posedge clk);
      #1;
      rdy_in = 1'b0;
   endtask

   task automatic test_reset();
      logic [67:0] act, exp;
      repeat (2) @(posedge clk);
      #1;
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
      for (int k = 0; k < 3; k++) begin
         act = {ov[k], ordy[k], zr[k], bs[k], od[k]};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL reset_held x%0d: {valid,ready,zero,busy,data}=%h expected %h",
                     WID[k], act, exp);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         act = {ov[k], ordy[k], zr[k], bs[k], od[k]};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL reset_released x%0d: {valid,ready,zero,busy,data}=%h expected %h",
                     WID[k], act, exp);
         end
      end
   endtask

   task automatic test_single_cycle();
      vec_t tbl[$];
      tbl.push_back(mk(4'(AluAdd), M8, M32, M64, 1, 1, 1, 0, 0, 0));
      tbl.push_back(mks(4'(AluSub), 5, 7, 64'hFE, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE));
      tbl.push_back(mks(4'(AluAnd), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                        64'h00, 64'hF000_F000, 64'hF000_F000_F000_F000));
      tbl.push_back(mks(4'(AluOr), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                        64'hF0, 64'hFFF0_FFF0, 64'hFFF0_FFF0_FFF0_FFF0));
      tbl.push_back(mks(4'(AluXor), 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                        64'hF0, 64'h0FF0_0FF0, 64'h0FF0_0FF0_0FF0_0FF0));
      tbl.push_back(mk(4'(AluSlt), 64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000,
                       1, 1, 1, 1, 1, 1));
      tbl.push_back(mk(4'(AluSltu), 64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000,
                       1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(4'(AluSlt), 1, 1, 1, 64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000,
                       0, 0, 0));
      tbl.push_back(mk(4'(AluSra), 64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000,
                       64'h21, 64'h21, 64'h41,
                       64'hC0, 64'hC000_0000, 64'hC000_0000_0000_0000));
      tbl.push_back(mk(4'(AluSll), 1, 1, 1, 64'h0F, 64'h3F, 64'h7F,
                       64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000));
      tbl.push_back(mk(4'(AluSrl), 64'h80, 64'h8000_0000, 64'h8000_0000_0000_0000,
                       64'h07, 64'h1F, 64'h3F, 1, 1, 1));
      tbl.push_back(mks(4'(AluRsv14), 5, 3, 0, 0, 0));
      tbl.push_back(mks(4'(AluRsv15), 64'hFF, 64'hFF, 0, 0, 0));
      foreach (tbl[i]) begin
         issue(tbl[i], 1'b1);
         collect();
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_data[k] !== tbl[i].e[k] || got_zero[k] !== (tbl[i].e[k] == 64'd0) ||
                got_lat[k] != 0 || busy_cnt[k] != 0) begin
               fails++;
               $display("FAIL single op%0d x%0d: data=%h zero=%b lat=%0d busy=%0d, %s %h lat=0 busy=0",
                        tbl[i].op, WID[k], got_data[k], got_zero[k], got_lat[k], busy_cnt[k],
                        "expected data", tbl[i].e[k]);
            end
         end
      end
   endtask

   task automatic test_muldiv();
      vec_t tbl[$];
      tbl.push_back(mk(4'(AluMul), 64'h10, 64'h1_0000, 64'h1_0000_0000,
                       64'h10, 64'h1_0000, 64'h1_0000_0000, 0, 0, 0));
      tbl.push_back(mk(4'(AluMulhu), 64'h10, 64'h1_0000, 64'h1_0000_0000,
                       64'h10, 64'h1_0000, 64'h1_0000_0000, 1, 1, 1));
      tbl.push_back(mk(4'(AluMul), M8, M32, M64, M8, M32, M64, 1, 1, 1));
      tbl.push_back(mk(4'(AluMulhu), M8, M32, M64, M8, M32, M64,
                       64'hFE, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE));
      tbl.push_back(mks(4'(AluDivu), 100, 7, 14, 14, 14));
      tbl.push_back(mks(4'(AluRemu), 100, 7, 2, 2, 2));
      tbl.push_back(mks(4'(AluDivu), 250, 9, 27, 27, 27));
      tbl.push_back(mks(4'(AluRemu), 250, 9, 7, 7, 7));
      tbl.push_back(mks(4'(AluDivu), 64'h1234, 0, M8, M32, M64));
      tbl.push_back(mks(4'(AluRemu), 64'h1234, 0, 64'h34, 64'h1234, 64'h1234));
      tbl.push_back(mk(4'(AluDivu), M8, M32, M64, 3, 3, 3,
                       64'h55, 64'h5555_5555, 64'h5555_5555_5555_5555));
      foreach (tbl[i]) begin
         issue(tbl[i], 1'b1);
         collect();
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_data[k] !== tbl[i].e[k] || got_zero[k] !== (tbl[i].e[k] == 64'd0) ||
                got_lat[k] != WID[k] || busy_cnt[k] != WID[k] || rdy_seen[k]) begin
               fails++;
               $display("FAIL muldiv op%0d x%0d: data=%h zero=%b lat=%0d busy=%0d ready=%b, %s %h lat=busy=%0d ready=0",
                        tbl[i].op, WID[k], got_data[k], got_zero[k], got_lat[k], busy_cnt[k],
                        rdy_seen[k], "expected data", tbl[i].e[k], WID[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [66:0] act, exp;
      issue(mks(4'(AluAdd), 2, 3, 5, 5, 5), 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 64'd5};
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (c == 1) begin
            // A new request while DONE must be ignored.
            ctl      = 4'(AluSub);
            a_in     = {64'd9, 64'd9, 64'd9};
            b_in     = {64'd1, 64'd1, 64'd1};
            in_valid = 1'b1;
         end
         for (int k = 0; k < 3; k++) begin
            act = {ov[k], ordy[k], zr[k], od[k]};
            tests++;
            if (act !== exp) begin
               fails++;
               $display("FAIL backpressure_hold c%0d x%0d: {valid,ready,zero,data}=%h expected %h",
                        c, WID[k], act, exp);
            end
         end
      end
      in_valid = 1'b0;
      rdy_in   = 1'b1;
      @(posedge clk);
      #1;
      rdy_in = 1'b0;
      exp = {1'b0, 1'b1, 1'b0, 64'd5};
      for (int k = 0; k < 3; k++) begin
         act = {ov[k], ordy[k], zr[k], od[k]};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL backpressure_release x%0d: {valid,ready,zero,data}=%h expected %h",
                     WID[k], act, exp);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         act = {ov[k], ordy[k], zr[k], od[k]};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL backpressure_idle x%0d: {valid,ready,zero,data}=%h expected %h",
                     WID[k], act, exp);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [67:0] act, exp;
      issue(mks(4'(AluDivu), 100, 7, 14, 14, 14), 1'b0);
      repeat (9) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      exp = {1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
      for (int k = 0; k < 3; k++) begin
         act = {ov[k], ordy[k], zr[k], bs[k], od[k]};
         tests++;
         if (act !== exp) begin
            fails++;
            $display("FAIL reset_mid_op x%0d: {valid,ready,zero,busy,data}=%h expected %h",
                     WID[k], act, exp);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(mks(4'(AluAdd), 2, 3, 5, 5, 5), 1'b1);
      collect();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (got_data[k] !== 64'd5 || got_zero[k] !== 1'b0 || got_lat[k] != 0) begin
            fails++;
            $display("FAIL add_after_reset x%0d: data=%h zero=%b lat=%0d expected data=5 zero=0 lat=0",
                     WID[k], got_data[k], got_zero[k], got_lat[k]);
         end
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      rdy_in   = 1'b0;
      ctl      = 4'd0;
      a_in     = '0;
      b_in     = '0;
      test_reset();
      test_single_cycle();
      test_muldiv();
      test_backpressure();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
